cs_measurement_streamer: RTL and testbench

Captures the parallel block of compressed-sensing measurements produced by the test-image reader and streams them, one word per cycle, to the reconstruction engine over a valid/ready handshake. While streaming, it accumulates the measurement energy (sum of squares, the initial residual norm²) and presents it once the last word has been accepted. It sits between the measurement source and the reconstruction datapath, and decouples the all-at-once source from the sequential consumer.

---
 rtl/cs_measurement_streamer.sv | 122 ++++++++++++
 tb/tb_cs_measurement_streamer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cs_measurement_streamer.sv
// Captures a parallel block of compressed-sensing measurements and streams them out one word per beat,
// accumulating the sum of squares (initial residual energy) as words are accepted.
module cs_measurement_streamer #(
  parameter int DATA_W = 16,
  parameter int MAX_M  = 48,
  parameter int ACC_W  = 40
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                meas_num,
  input  logic [DATA_W*MAX_M-1:0]   meas_in,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [5:0]                out_index,
  output logic                      out_last,
  output logic [ACC_W-1:0]          energy,
  output logic                      energy_valid,
  output logic                      err
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t                  r_state;
  logic [DATA_W-1:0]       r_buf [MAX_M];
  logic [5:0]              r_index;
  logic [5:0]              r_last_idx;
  logic                    r_valid;
  logic                    r_busy;
  logic                    r_energy_valid;
  logic                    r_err;
  logic [ACC_W-1:0]        r_energy;

  logic                    w_legal;
  logic                    w_capture;
  logic                    w_xfer;
  logic                    w_is_last;
  logic signed [DATA_W-1:0]   w_cur;
  logic signed [2*DATA_W-1:0] w_sq;
  logic [DATA_W-1:0]       w_cap_word [MAX_M];

  assign w_legal   = (meas_num == 8'd16) || (meas_num == 8'd32) ||
                     ((meas_num == 8'd48) && (MAX_M >= 48));
  assign w_capture = (r_state == S_IDLE) && start && w_legal;
  assign w_xfer    = r_valid && out_ready;
  assign w_is_last = (r_index == r_last_idx);
  assign w_cur     = r_buf[r_index];
  assign w_sq      = w_cur * w_cur;

  // Entries at or beyond meas_num are zeroed so stale data from a longer block never lingers.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_M; gi++) begin : g_cap
      localparam logic [7:0] LP_IDX = 8'(gi);
      assign w_cap_word[gi] = (LP_IDX < meas_num) ? meas_in[DATA_W*gi +: DATA_W] : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_index        <= '0;
      r_last_idx     <= '0;
      r_valid        <= 1'b0;
      r_busy         <= 1'b0;
      r_energy_valid <= 1'b0;
      r_err          <= 1'b0;
      r_energy       <= '0;
      for (int i = 0; i < MAX_M; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_legal) begin
              for (int i = 0; i < MAX_M; i++) r_buf[i] <= w_cap_word[i];
              r_last_idx <= 6'(meas_num - 8'd1);
              r_index    <= '0;
              r_energy   <= '0;
              r_err      <= 1'b0;
              r_valid    <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_STREAM;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            r_energy <= r_energy + {{(ACC_W-2*DATA_W){1'b0}}, w_sq};
            // Index parks on the last element so the buffer read never leaves range.
            if (w_is_last) begin
              r_valid        <= 1'b0;
              r_energy_valid <= 1'b1;
              r_state        <= S_DONE;
            end else begin
              r_index <= r_index + 6'd1;
            end
          end
        end
        S_DONE: begin
          r_energy_valid <= 1'b0;
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign out_valid    = r_valid;
  assign out_data     = r_valid ? w_cur : '0;
  assign out_index    = r_valid ? r_index : '0;
  assign out_last     = r_valid && w_is_last;
  assign energy       = r_energy;
  assign energy_valid = r_energy_valid;
  assign err          = r_err;

endmodule

// File: tb/tb_cs_measurement_streamer.sv
// Directed bench for cs_measurement_streamer: stimulus pushes expected beats and energies into
// queues, an independent monitor pops and compares whenever the DUT presents them.
module tb_cs_measurement_streamer;

  localparam int DATA_W = 16;
  localparam int MAX_M  = 48;
  localparam int ACC_W  = 40;
  localparam int VEC_W  = DATA_W * MAX_M;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic [7:0]           meas_num = '0;
  logic [VEC_W-1:0]     meas_in = '0;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [DATA_W-1:0]    out_data;
  logic [5:0]           out_index;
  logic                 out_last;
  logic [ACC_W-1:0]     energy;
  logic                 energy_valid;
  logic                 err;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [5:0]        idx;
    logic              last;
  } beat_t;

  beat_t            beat_q[$];
  logic [ACC_W-1:0] energy_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  cs_measurement_streamer #(.DATA_W(DATA_W), .MAX_M(MAX_M), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .start(start), .meas_num(meas_num), .meas_in(meas_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .energy(energy),
    .energy_valid(energy_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", {out_data, out_index, out_last}, 64'h0);
        end else if (out_ready) begin
          beat_t e;
          e = beat_q.pop_front();
          chk($sformatf("beat[%0d]", e.idx), {out_data, out_index, out_last}, {e.d, e.idx, e.last});
        end else begin
          chk($sformatf("stall[%0d]", beat_q[0].idx), {out_data, out_index, out_last},
              {beat_q[0].d, beat_q[0].idx, beat_q[0].last});
        end
      end
      if (energy_valid) begin
        if (energy_q.size() == 0) chk("unexpected_energy_valid", 64'(energy_valid), 64'h0);
        else chk("energy", 64'(energy), 64'(energy_q.pop_front()));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int num, input logic [VEC_W-1:0] data,
                          input logic accept, input logic [ACC_W-1:0] exp_e);
    meas_num = 8'(num);
    meas_in  = data;
    start    = 1'b1;
    if (accept) begin
      for (int i = 0; i < num; i++) begin
        beat_t b;
        b.d    = data[DATA_W*i +: DATA_W];
        b.idx  = 6'(i);
        b.last = (i == num - 1);
        beat_q.push_back(b);
      end
      energy_q.push_back(exp_e);
    end
    tick();
    start = 1'b0;
  endtask

  // Returns cycles waited; a timeout is recorded as a failed check.
  task automatic wait_ev(input bit toggle, output int n);
    n = 0;
    while (!energy_valid && n < 300) begin
      if (toggle) out_ready = ~out_ready;
      tick();
      n++;
    end
    chk("energy_valid_seen", 64'(energy_valid), 64'h1);
    chk("busy_during_ev", 64'(busy), 64'h1);
    out_ready = 1'b1;
    tick();
    chk("ev_one_cycle", 64'(energy_valid), 64'h0);
    chk("busy_falls", 64'(busy), 64'h0);
  endtask

  logic [VEC_W-1:0] v_a, v_b, v_c, v_d, v_e;
  int n;

  initial begin
    for (int i = 0; i < MAX_M; i++) begin
      v_a[DATA_W*i +: DATA_W] = (i < 16) ? 16'(i + 1) : 16'h7777;   // tail must be dropped
      v_b[DATA_W*i +: DATA_W] = 16'hFFFF;
      v_c[DATA_W*i +: DATA_W] = 16'h8000;
      v_d[DATA_W*i +: DATA_W] = 16'(-(i + 1));
      v_e[DATA_W*i +: DATA_W] = 16'(3 * i + 5);
    end

    tick(); tick();
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_outputs", {out_data, out_index, out_last, energy_valid, err}, 64'h0);
    chk("rst_energy", 64'(energy), 64'h0);
    reset = 1'b1;
    out_ready = 1'b1;
    tick();

    // 16 words of i+1, full throughput: sum 1..16 squared = 1496.
    do_start(16, v_a, 1'b1, 40'd1496);
    chk("first_valid", {out_valid, out_index}, {1'b1, 6'd0});
    wait_ev(1'b0, n);
    chk("latency16", 64'(n), 64'd16);

    // 48 words of -1: energy 48; then 32 words of -32768 started as busy falls.
    do_start(48, v_b, 1'b1, 40'd48);
    wait_ev(1'b0, n);
    chk("latency48", 64'(n), 64'd48);
    do_start(32, v_c, 1'b1, 40'h8_0000_0000);
    chk("start_on_idle_edge", 64'(busy), 64'h1);
    wait_ev(1'b0, n);

    // 32 words of -(i+1), ready toggling: sum 1..32 squared = 11440.
    do_start(32, v_d, 1'b1, 40'd11440);
    wait_ev(1'b1, n);

    // Illegal count, then a legal one clears err.
    do_start(20, v_e, 1'b0, '0);
    chk("illegal_err", 64'(err), 64'h1);
    chk("illegal_idle", {busy, out_valid}, 64'h0);
    chk("illegal_energy_kept", 64'(energy), 64'd11440);
    do_start(16, v_a, 1'b1, 40'd1496);
    chk("err_cleared", 64'(err), 64'h0);
    wait_ev(1'b0, n);

    // Start during streaming is ignored.
    do_start(16, v_a, 1'b1, 40'd1496);
    tick(); tick();
    do_start(48, v_e, 1'b0, '0);
    chk("busy_start_err", 64'(err), 64'h0);
    wait_ev(1'b0, n);

    // Reset after 5 transfers of a 48-word block.
    do_start(48, v_e, 1'b1, '0);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("midrst_valid", 64'(out_valid), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_energy", 64'(energy), 64'h0);
    chk("midrst_consumed", 64'(beat_q.size()), 64'd43);
    beat_q.delete();
    energy_q.delete();
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("post_rst_idle", {busy, out_valid, energy_valid}, 64'h0);

    chk("beats_drained", 64'(beat_q.size()), 64'h0);
    chk("energies_drained", 64'(energy_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
